bilinear_fetch_ctrl: RTL and testbench

Upstream feeder for the bilinear interpolation datapath. For each destination pixel in raster order it derives the source coordinates and Q0.8 fractions from programmable Q8.8 step sizes. It then reads the four neighbouring source pixels from a single-port synchronous pixel memory. Finally it presents the quad plus alpha/beta with a one-cycle valid strobe, in the exact format the interpolator consumes: I00, I10, I01, I11, alpha and beta, all 8 bits, with no backpressure.

---
 rtl/bilinear_fetch_ctrl_pkg.sv | 27 ++
 rtl/bilinear_fetch_ctrl_if.sv | 32 +++
 rtl/bilinear_fetch_ctrl_axis_step.sv | 62 ++++++
 rtl/bilinear_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_bilinear_fetch_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bilinear_fetch_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bilinear_pkg : shared widths and FSM encoding for the fetch ctrl |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package bilinear_pkg;

  localparam int COORD_W = 8;
  localparam int FRAC_W  = 8;
  localparam int ACC_W   = 24;
  localparam int ADDR_W  = 16;
  localparam int PIX_W   = 8;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CALC = 4'd1,
    ST_R00  = 4'd2,
    ST_R10  = 4'd3,
    ST_R01  = 4'd4,
    ST_R11  = 4'd5,
    ST_CAP  = 4'd6,
    ST_OUT  = 4'd7,
    ST_DONE = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bilinear_fetch_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bilinear_fetch_ctrl_if : pixel-memory port and quad output bus   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface bilinear_fetch_ctrl_if #(
  parameter int ADDR_W = bilinear_pkg::ADDR_W
);

  logic                           mem_rd;
  logic [ADDR_W-1:0]              mem_addr;
  logic [bilinear_pkg::PIX_W-1:0] mem_rdata;
  logic                           valid_out;
  logic [bilinear_pkg::PIX_W-1:0] I00;
  logic [bilinear_pkg::PIX_W-1:0] I10;
  logic [bilinear_pkg::PIX_W-1:0] I01;
  logic [bilinear_pkg::PIX_W-1:0] I11;
  logic [bilinear_pkg::PIX_W-1:0] alpha;
  logic [bilinear_pkg::PIX_W-1:0] beta;

  modport master (
    output mem_rd, mem_addr, valid_out, I00, I10, I01, I11, alpha, beta,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd, mem_addr, valid_out, I00, I10, I01, I11, alpha, beta,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/bilinear_fetch_ctrl_axis_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bilinear_axis_step : 16.8 axis accumulator with edge clamp       |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module bilinear_axis_step
  import bilinear_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add,
  input  logic [15:0]        step,
  input  logic [COORD_W-1:0] size,
  output logic [COORD_W-1:0] coord0,
  output logic [COORD_W-1:0] coord1,
  output logic [FRAC_W-1:0]  frac
);

  localparam int INT_W = ACC_W - FRAC_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum_w;
  logic [INT_W-1:0] int_w;
  logic [INT_W-1:0] last_w;

  // Saturate rather than wrap so a runaway step stays pinned to the edge
  always_comb begin
    sum_w = {1'b0, acc_q} + (ACC_W+1)'(step);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign int_w  = acc_q[ACC_W-1:FRAC_W];
  assign last_w = INT_W'(size) - INT_W'(1);

  always_comb begin
    if (int_w >= last_w) begin
      coord0 = size - COORD_W'(1);
      coord1 = size - COORD_W'(1);
      frac   = '0;
    end else begin
      coord0 = int_w[COORD_W-1:0];
      coord1 = int_w[COORD_W-1:0] + COORD_W'(1);
      frac   = acc_q[FRAC_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bilinear_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bilinear_fetch_ctrl : raster walker fetching 2x2 quads + fracs   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module bilinear_fetch_ctrl #(
  parameter int ADDR_W  = bilinear_pkg::ADDR_W,
  parameter int COORD_W = bilinear_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] src_w,
  input  logic [COORD_W-1:0] src_h,
  input  logic [COORD_W-1:0] dst_w,
  input  logic [COORD_W-1:0] dst_h,
  input  logic [15:0]        step_x,
  input  logic [15:0]        step_y,
  output logic               busy,
  output logic               done,
  bilinear_fetch_ctrl_if.master bus
);

  import bilinear_pkg::*;

  localparam logic [3:0] S_IDLE = ST_IDLE;
  localparam logic [3:0] S_CALC = ST_CALC;
  localparam logic [3:0] S_R00  = ST_R00;
  localparam logic [3:0] S_R10  = ST_R10;
  localparam logic [3:0] S_R01  = ST_R01;
  localparam logic [3:0] S_R11  = ST_R11;
  localparam logic [3:0] S_CAP  = ST_CAP;
  localparam logic [3:0] S_OUT  = ST_OUT;
  localparam logic [3:0] S_DONE = ST_DONE;

  logic [3:0]         state_q, state_d;
  logic [COORD_W-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
  logic [COORD_W-1:0] dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [15:0]        step_x_q, step_x_d, step_y_q, step_y_d;
  logic [COORD_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [ADDR_W-1:0]  row0_q, row0_d, row1_q, row1_d;
  logic [7:0]         ax_q, ax_d, by_q, by_d;
  logic [7:0]         p00_q, p00_d, p10_q, p10_d, p01_q, p01_d;
  logic [7:0]         i00_q, i00_d, i10_q, i10_d, i01_q, i01_d, i11_q, i11_d;
  logic [7:0]         alpha_q, alpha_d, beta_q, beta_d;

  logic [COORD_W-1:0] xc0_w, xc1_w, yc0_w, yc1_w;
  logic [7:0]         xf_w, yf_w;
  logic               idle_start_w, zero_w, last_col_w, last_row_w;
  logic               x_clr_w, x_add_w, y_clr_w, y_add_w;
  logic [ADDR_W-1:0]  mem_addr_w;

  assign idle_start_w = (state_q == S_IDLE) && start;
  assign zero_w       = (src_w == '0) || (src_h == '0) || (dst_w == '0) || (dst_h == '0);
  assign last_col_w   = (x_cnt_q == dst_w_q - COORD_W'(1));
  assign last_row_w   = (y_cnt_q == dst_h_q - COORD_W'(1));

  // x restarts at every row end; y only at frame start
  assign x_clr_w = idle_start_w || ((state_q == S_OUT) && last_col_w);
  assign x_add_w = (state_q == S_OUT) && !last_col_w;
  assign y_clr_w = idle_start_w;
  assign y_add_w = (state_q == S_OUT) && last_col_w;

  bilinear_axis_step u_axis_x (
    .clk    (clk),
    .rst    (rst),
    .clr    (x_clr_w),
    .add    (x_add_w),
    .step   (step_x_q),
    .size   (src_w_q),
    .coord0 (xc0_w),
    .coord1 (xc1_w),
    .frac   (xf_w)
  );

  bilinear_axis_step u_axis_y (
    .clk    (clk),
    .rst    (rst),
    .clr    (y_clr_w),
    .add    (y_add_w),
    .step   (step_y_q),
    .size   (src_h_q),
    .coord0 (yc0_w),
    .coord1 (yc1_w),
    .frac   (yf_w)
  );

  always_comb begin
    state_d  = state_q;
    src_w_d  = src_w_q;
    src_h_d  = src_h_q;
    dst_w_d  = dst_w_q;
    dst_h_d  = dst_h_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    row0_d   = row0_q;
    row1_d   = row1_q;
    ax_d     = ax_q;
    by_d     = by_q;
    p00_d    = p00_q;
    p10_d    = p10_q;
    p01_d    = p01_q;
    i00_d    = i00_q;
    i10_d    = i10_q;
    i01_d    = i01_q;
    i11_d    = i11_q;
    alpha_d  = alpha_q;
    beta_d   = beta_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_w_d  = src_w;
          src_h_d  = src_h;
          dst_w_d  = dst_w;
          dst_h_d  = dst_h;
          step_x_d = step_x;
          step_y_d = step_y;
          x_cnt_d  = '0;
          y_cnt_d  = '0;
          state_d  = zero_w ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        x0_d    = xc0_w;
        x1_d    = xc1_w;
        row0_d  = ADDR_W'(yc0_w) * ADDR_W'(src_w_q);
        row1_d  = ADDR_W'(yc1_w) * ADDR_W'(src_w_q);
        ax_d    = xf_w;
        by_d    = yf_w;
        state_d = S_R00;
      end
      S_R00: state_d = S_R10;
      S_R10: begin
        p00_d   = bus.mem_rdata;
        state_d = S_R01;
      end
      S_R01: begin
        p10_d   = bus.mem_rdata;
        state_d = S_R11;
      end
      S_R11: begin
        p01_d   = bus.mem_rdata;
        state_d = S_CAP;
      end
      // Output registers update only here so they stay frozen outside OUT
      S_CAP: begin
        i00_d   = p00_q;
        i10_d   = p10_q;
        i01_d   = p01_q;
        i11_d   = bus.mem_rdata;
        alpha_d = ax_q;
        beta_d  = by_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (last_col_w) begin
          x_cnt_d = '0;
          y_cnt_d = y_cnt_q + COORD_W'(1);
          state_d = last_row_w ? S_DONE : S_CALC;
        end else begin
          x_cnt_d = x_cnt_q + COORD_W'(1);
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_w_q  <= '0;
      src_h_q  <= '0;
      dst_w_q  <= '0;
      dst_h_q  <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      row0_q   <= '0;
      row1_q   <= '0;
      ax_q     <= '0;
      by_q     <= '0;
      p00_q    <= '0;
      p10_q    <= '0;
      p01_q    <= '0;
      i00_q    <= '0;
      i10_q    <= '0;
      i01_q    <= '0;
      i11_q    <= '0;
      alpha_q  <= '0;
      beta_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_w_q  <= src_w_d;
      src_h_q  <= src_h_d;
      dst_w_q  <= dst_w_d;
      dst_h_q  <= dst_h_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      row0_q   <= row0_d;
      row1_q   <= row1_d;
      ax_q     <= ax_d;
      by_q     <= by_d;
      p00_q    <= p00_d;
      p10_q    <= p10_d;
      p01_q    <= p01_d;
      i00_q    <= i00_d;
      i10_q    <= i10_d;
      i01_q    <= i01_d;
      i11_q    <= i11_d;
      alpha_q  <= alpha_d;
      beta_q   <= beta_d;
    end
  end

  always_comb begin
    mem_addr_w = '0;
    case (state_q)
      S_R00:   mem_addr_w = row0_q + ADDR_W'(x0_q);
      S_R10:   mem_addr_w = row0_q + ADDR_W'(x1_q);
      S_R01:   mem_addr_w = row1_q + ADDR_W'(x0_q);
      S_R11:   mem_addr_w = row1_q + ADDR_W'(x1_q);
      default: mem_addr_w = '0;
    endcase
  end

  assign bus.mem_addr  = mem_addr_w;
  assign bus.mem_rd    = (state_q == S_R00) || (state_q == S_R10) ||
                         (state_q == S_R01) || (state_q == S_R11);
  assign bus.valid_out = (state_q == S_OUT);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign bus.I00       = i00_q;
  assign bus.I10       = i10_q;
  assign bus.I01       = i01_q;
  assign bus.I11       = i11_q;
  assign bus.alpha     = alpha_q;
  assign bus.beta      = beta_q;

endmodule
`default_nettype wire

// File: tb/tb_bilinear_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bilinear_fetch_ctrl : frame-level checks against a pixel model|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_bilinear_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  src_w, src_h, dst_w, dst_h;
  logic [15:0] step_x, step_y;
  logic        busy, done;
  logic [7:0]  mem [0:65535];
  int          n_cmp = 0;
  int          n_bad = 0;

  bilinear_fetch_ctrl_if #(.ADDR_W(16)) bus_if ();

  bilinear_fetch_ctrl #(.ADDR_W(16), .COORD_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .src_w  (src_w),
    .src_h  (src_h),
    .dst_w  (dst_w),
    .dst_h  (dst_h),
    .step_x (step_x),
    .step_y (step_y),
    .busy   (busy),
    .done   (done),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: data appears the cycle after the read
  always @(posedge clk) begin
    if (bus_if.mem_rd) bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Position idx along one axis: coordinate pair and fraction
  function automatic void axis_ref(input int unsigned idx, input int unsigned step,
                                   input int unsigned size, output int unsigned c0,
                                   output int unsigned c1, output int unsigned f);
    longint unsigned acc;
    longint unsigned ip;
    acc = longint'(idx) * longint'(step);
    if (acc > 64'hFFFFFF) acc = 64'hFFFFFF;
    ip = acc >> 8;
    if (ip >= longint'(size) - 1) begin
      c0 = size - 1;
      c1 = size - 1;
      f  = 0;
    end else begin
      c0 = int'(ip);
      c1 = int'(ip) + 1;
      f  = int'(acc % 256);
    end
  endfunction

  task automatic run_frame(input string name, input int sw, input int sh, input int dw,
                           input int dh, input int sx, input int sy,
                           input int poke_at, input int rst_at);
    logic [47:0] exp_q[$];
    logic [47:0] e;
    logic [47:0] got;
    int unsigned x0, x1, y0, y1, fa, fb;
    int n, k, rd_cnt;
    n = (sw == 0 || sh == 0) ? 0 : dw * dh;
    for (int j = 0; j < dh && n > 0; j++) begin
      for (int i = 0; i < dw; i++) begin
        axis_ref(i, sx, sw, x0, x1, fa);
        axis_ref(j, sy, sh, y0, y1, fb);
        exp_q.push_back({mem[y0*sw + x0], mem[y0*sw + x1], mem[y1*sw + x0],
                         mem[y1*sw + x1], fa[7:0], fb[7:0]});
      end
    end
    k = 0;
    rd_cnt = 0;
    @(negedge clk);
    src_w = sw[7:0]; src_h = sh[7:0]; dst_w = dw[7:0]; dst_h = dh[7:0];
    step_x = sx[15:0]; step_y = sy[15:0];
    start = 1'b1;
    for (int c = 1; c <= 7*n + 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == rst_at) begin
        check_eq({name, "_pre_rst_rd"}, bus_if.mem_rd, 1);
        rst = 1'b1;
        #1;
        check_eq({name, "_rst_ctl"}, {busy, done, bus_if.valid_out, bus_if.mem_rd, bus_if.mem_addr}, 0);
        check_eq({name, "_rst_dat"}, {bus_if.I00, bus_if.I10, bus_if.I01, bus_if.I11,
                                     bus_if.alpha, bus_if.beta}, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (bus_if.mem_rd) rd_cnt++;
      check_eq({name, "_busy"}, busy, 1);
      if (bus_if.valid_out) begin
        check_eq({name, "_vcyc"}, c, 7*(k+1));
        got = {bus_if.I00, bus_if.I10, bus_if.I01, bus_if.I11, bus_if.alpha, bus_if.beta};
        if (exp_q.size() == 0) begin
          check_eq({name, "_extra_valid"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq({name, "_quad"}, got, e);
        end
        k++;
      end
      if (done) begin
        check_eq({name, "_done_cyc"}, c, 7*n + 1);
        check_eq({name, "_npix"}, k, n);
        check_eq({name, "_nrd"}, rd_cnt, 4*n);
        @(negedge clk);
        check_eq({name, "_idle_after"}, {busy, done}, 0);
        return;
      end
      if (c == poke_at) begin
        start = 1'b1;
        src_w = 8'd9; dst_w = dw[7:0] + 8'd2; dst_h = dh[7:0] + 8'd1;
      end
    end
    check_eq({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int sw, sh, dw, dh, sx, sy;
    rst = 1'b1;
    start = 1'b0;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0;
    step_x = '0; step_y = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a + 10);
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", {busy, done, bus_if.valid_out, bus_if.mem_rd, bus_if.mem_addr}, 0);
    check_eq("reset_dat", {bus_if.I00, bus_if.I10, bus_if.I01, bus_if.I11,
                           bus_if.alpha, bus_if.beta}, 0);
    rst = 1'b0;

    run_frame("ident",      2, 2, 2, 2, 'h100, 'h100, 0, 0);
    check_eq("ident_last_hold", {bus_if.I00, bus_if.I10, bus_if.I01, bus_if.I11}, 32'h0D0D0D0D);
    run_frame("upscale",    2, 2, 4, 1, 'h080, 'h100, 0, 0);
    run_frame("zero_dst",   2, 2, 0, 2, 'h100, 'h100, 0, 0);
    run_frame("zero_src",   0, 3, 2, 2, 'h100, 'h100, 0, 0);
    run_frame("rst_mid",    2, 2, 2, 2, 'h100, 'h100, 0, 4);
    run_frame("ident_again", 2, 2, 2, 2, 'h100, 'h100, 0, 0);
    run_frame("busy_start", 3, 3, 3, 2, 'h100, 'h080, 10, 0);

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      sw = $urandom_range(1, 6);
      sh = $urandom_range(1, 6);
      dw = $urandom_range(1, 5);
      dh = $urandom_range(1, 5);
      sx = (t % 4 == 3) ? $urandom_range(0, 65535) : $urandom_range(0, 1023);
      sy = (t % 4 == 2) ? $urandom_range(0, 65535) : $urandom_range(0, 1023);
      run_frame("rand", sw, sh, dw, dh, sx, sy, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
